// File: rtl/sum_threshold_acc.sv
// Sum-and-threshold neuron node: gathers one partial sum per PE per timestep,
// fires a spike packet when the membrane reaches THRESH, then writes back the residual.
module sum_threshold_acc #(
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned PAD_W      = 15,
    parameter int unsigned N_PE       = 10,
    parameter logic [N_PE*ADDR_W-1:0] PE_ADDRS = 40'hBF26AE159D,
    parameter int unsigned SUM_W      = 16,
    parameter int unsigned THRESH     = 64,
    parameter int unsigned RESET_MODE = 0,
    parameter int unsigned SEND_ZERO  = 1,
    parameter logic [ADDR_W-1:0] MY_ADDR  = 4'h0,
    parameter logic [ADDR_W-1:0] RES_ADDR = 4'hC,
    parameter logic [ADDR_W-1:0] OUT_ADDR = 4'h3,
    localparam int unsigned PKT_W     = 3*ADDR_W + PAD_W + DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PKT_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PKT_W-1:0] out_data,
    output logic [15:0]      ts_count,
    output logic             err_pulse
);

    typedef enum logic [1:0] {COLLECT, FIRE, SEND_SPK, SEND_RES} state_t;

    state_t            state, state_nxt;
    logic              in_ready_nxt, out_valid_nxt, err_nxt, spike_q, spike_nxt;
    logic [PKT_W-1:0]  out_data_nxt;
    logic [15:0]       ts_nxt;
    logic [SUM_W-1:0]  acc, acc_nxt, mem, mem_nxt;
    logic [N_PE-1:0]   recv_mask, mask_nxt, pe_vec;

    logic [ADDR_W-1:0] src, dst;
    logic [DATA_W-1:0] pdata, res_data;
    logic [SUM_W-1:0]  pot, mem_fire;
    logic              spike_c;
    logic [PKT_W-1:0]  spk_pkt, res_pkt;
    logic              unused_bits;

    function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                                 input logic [SUM_W-1:0] b);
        logic [SUM_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SUM_W] ? '1 : s[SUM_W-1:0];
    endfunction

    // Packet field decode and source lookup (one-hot over PE list)
    always_comb begin
        src   = in_data[PKT_W-1 -: ADDR_W];
        dst   = in_data[PKT_W-1-ADDR_W -: ADDR_W];
        pdata = in_data[DATA_W-1:0];
        for (int i = 0; i < N_PE; i++) begin
            pe_vec[i] = (src == PE_ADDRS[(N_PE-1-i)*ADDR_W +: ADDR_W]);
        end
    end

    assign unused_bits = ^in_data[PKT_W-1-2*ADDR_W:DATA_W];

    // Membrane update and outgoing packet images
    always_comb begin
        pot      = sat_add(mem, acc);
        spike_c  = (pot >= SUM_W'(THRESH));
        if (!spike_c)             mem_fire = pot;
        else if (RESET_MODE != 0) mem_fire = '0;
        else                      mem_fire = pot - SUM_W'(THRESH);
        res_data = (mem > SUM_W'({DATA_W{1'b1}})) ? '1 : mem[DATA_W-1:0];
        spk_pkt  = {MY_ADDR, OUT_ADDR, MY_ADDR, PAD_W'(0), DATA_W'(spike_q)};
        res_pkt  = {MY_ADDR, RES_ADDR, MY_ADDR, PAD_W'(0), res_data};
    end

    always_comb begin
        state_nxt     = state;
        out_valid_nxt = out_valid;
        out_data_nxt  = out_data;
        ts_nxt        = ts_count;
        err_nxt       = 1'b0;
        acc_nxt       = acc;
        mem_nxt       = mem;
        mask_nxt      = recv_mask;
        spike_nxt     = spike_q;
        case (state)
            COLLECT: begin
                if (in_valid && in_ready) begin
                    if (dst != MY_ADDR) begin
                        err_nxt = 1'b1;
                    end else if (src == RES_ADDR) begin
                        mem_nxt = SUM_W'(pdata);
                    end else if (pe_vec == '0 || (pe_vec & recv_mask) != '0) begin
                        err_nxt = 1'b1;
                    end else begin
                        acc_nxt  = sat_add(acc, SUM_W'(pdata));
                        mask_nxt = recv_mask | pe_vec;
                        if (&mask_nxt) state_nxt = FIRE;
                    end
                end
            end
            FIRE: begin
                mem_nxt   = mem_fire;
                spike_nxt = spike_c;
                acc_nxt   = '0;
                mask_nxt  = '0;
                state_nxt = (SEND_ZERO != 0 || spike_c) ? SEND_SPK : SEND_RES;
            end
            SEND_SPK: begin
                if (!out_valid) begin
                    out_valid_nxt = 1'b1;
                    out_data_nxt  = spk_pkt;
                end else if (out_ready) begin
                    out_data_nxt = res_pkt;
                    state_nxt    = SEND_RES;
                end
            end
            SEND_RES: begin
                if (!out_valid) begin
                    out_valid_nxt = 1'b1;
                    out_data_nxt  = res_pkt;
                end else if (out_ready) begin
                    out_valid_nxt = 1'b0;
                    ts_nxt        = ts_count + 16'd1;
                    state_nxt     = COLLECT;
                end
            end
            default: state_nxt = COLLECT;
        endcase
        in_ready_nxt = (state_nxt == COLLECT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= COLLECT;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            ts_count  <= '0;
            err_pulse <= 1'b0;
            acc       <= '0;
            mem       <= '0;
            recv_mask <= '0;
            spike_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
            ts_count  <= ts_nxt;
            err_pulse <= err_nxt;
            acc       <= acc_nxt;
            mem       <= mem_nxt;
            recv_mask <= mask_nxt;
            spike_q   <= spike_nxt;
        end
    end

endmodule

// File: tb/tb_sum_threshold_acc.sv
// Scoreboard bench for sum_threshold_acc: a reference model pushes expected output
// packets as partials are accepted; a monitor pops and compares on each output handshake.
module tb_sum_threshold_acc;

    localparam int unsigned PKT_W = 35;

    logic             clk = 1'b0;
    logic             rst_n, in_valid, in_ready, out_valid, out_ready, err_pulse;
    logic [PKT_W-1:0] in_data, out_data;
    logic [15:0]      ts_count;

    sum_threshold_acc dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .ts_count(ts_count), .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] PE_LIST [10] = '{4'hB, 4'hF, 4'h2, 4'h6, 4'hA,
                                            4'hE, 4'h1, 4'h5, 4'h9, 4'hD};

    int n_cmp = 0, n_err = 0;
    int err_seen = 0, err_exp = 0;
    int m_acc = 0, m_mem = 0, ts_exp = 0;
    bit m_mask [10];
    logic [PKT_W-1:0] exp_q [$];
    logic [7:0] last_res = 8'hFF, last_spk = 8'hFF;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [PKT_W-1:0] pkt(input logic [3:0] s, input logic [3:0] d,
                                             input logic [7:0] v);
        return {s, d, s, 15'b0, v};
    endfunction

    // Reference model of one accepted packet
    task automatic model_accept(input logic [3:0] s, input logic [3:0] d, input logic [7:0] v);
        int idx = -1;
        bit all_set = 1'b1;
        int pot;
        bit spike;
        if (d != 4'h0) begin
            err_exp++;
            return;
        end
        if (s == 4'hC) begin
            m_mem = int'(v);
            return;
        end
        for (int i = 0; i < 10; i++) if (PE_LIST[i] == s) idx = i;
        if (idx < 0 || m_mask[idx]) begin
            err_exp++;
            return;
        end
        m_acc = m_acc + int'(v);
        if (m_acc > 65535) m_acc = 65535;
        m_mask[idx] = 1'b1;
        for (int i = 0; i < 10; i++) if (!m_mask[i]) all_set = 1'b0;
        if (!all_set) return;
        pot = m_mem + m_acc;
        if (pot > 65535) pot = 65535;
        spike = (pot >= 64);
        m_mem = spike ? pot - 64 : pot;
        exp_q.push_back(pkt(4'h0, 4'h3, {7'b0, spike}));
        exp_q.push_back(pkt(4'h0, 4'hC, (m_mem > 255) ? 8'hFF : 8'(m_mem)));
        m_acc = 0;
        foreach (m_mask[i]) m_mask[i] = 1'b0;
        ts_exp++;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [3:0] s, input logic [3:0] d, input logic [7:0] v);
        bit ok = 1'b0;
        in_data  = pkt(s, d, v);
        in_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (ok) model_accept(s, d, v);
        else check("in_accept_timeout", 64'(in_ready), 64'd1);
    endtask

    // PE i sends i+1, visiting PEs in a stride-permuted order
    task automatic send_all(input int stride, input int skip_pe);
        for (int k = 0; k < 10; k++) begin
            int i = (k * stride) % 10;
            if (i != skip_pe) send(PE_LIST[i], 4'h0, 8'(i + 1));
        end
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({tag, "_idle_timeout"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_ts_count"}, 64'(ts_count), 64'(ts_exp));
        @(posedge clk);
        #1;
    endtask

    // Output monitor: a handshake happens at the next posedge
    always @(negedge clk) begin
        if (rst_n) begin
            if (err_pulse) err_seen++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("out_unexpected", 64'(exp_q.size()), 64'd1);
                else check("out_pkt", 64'(out_data), 64'(exp_q.pop_front()));
                if (out_data[30:27] == 4'hC) last_res = out_data[7:0];
                else if (out_data[30:27] == 4'h3) last_spk = out_data[7:0];
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"},  64'(in_ready),  64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_data"},  64'(out_data),  64'd0);
        check({tag, "_ts_count"},  64'(ts_count),  64'd0);
        check({tag, "_err_pulse"}, 64'(err_pulse), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int err_before;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("rst");
        rst_n = 1'b1;
        #1;
        check("rst_in_ready_hold", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("rst_in_ready_up", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // T1: sum 55, no spike; latency of out_valid and in_ready
        send_all(3, -1);
        @(negedge clk); check("t1_lat_fire", 64'(out_valid), 64'd0);
        @(negedge clk); check("t1_lat_p1",   64'(out_valid), 64'd0);
        @(negedge clk); check("t1_lat_p2",   64'(out_valid), 64'd1);
        @(negedge clk); check("t1_rdy_p3",   64'(in_ready),  64'd0);
        @(negedge clk); check("t1_rdy_p4",   64'(in_ready),  64'd1);
        @(posedge clk); #1;
        wait_idle("t1");
        check("t1_spk", 64'(last_spk), 64'd0);
        check("t1_res", 64'(last_res), 64'd55);

        // T2: 55 + 55 = 110, spike, residual 46
        send_all(7, -1);
        wait_idle("t2");
        check("t2_spk", 64'(last_spk), 64'd1);
        check("t2_res", 64'(last_res), 64'd46);

        // T3: residual override 11, then 55 -> 66, residual 2
        send(4'hC, 4'h0, 8'd11);
        send_all(1, -1);
        wait_idle("t3");
        check("t3_spk", 64'(last_spk), 64'd1);
        check("t3_res", 64'(last_res), 64'd2);

        // T4: duplicate, unknown source and misaddressed packets are dropped
        send(4'hC, 4'h0, 8'd0);
        err_before = err_seen;
        send(4'hB, 4'h0, 8'd1);
        send(4'hB, 4'h0, 8'd9);
        send(4'h7, 4'h0, 8'd3);
        send(4'hF, 4'h5, 8'd2);
        send_all(3, 0);
        wait_idle("t4");
        check("t4_err_count", 64'(err_seen - err_before), 64'd3);
        check("t4_spk", 64'(last_spk), 64'd0);
        check("t4_res", 64'(last_res), 64'd55);

        // T5: stall the spike packet; input offered meanwhile must wait, not vanish
        out_ready = 1'b0;
        send_all(9, -1);
        fork
            begin
                bit seen = 1'b0;
                for (int c = 0; c < 50; c++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        seen = 1'b1;
                        break;
                    end
                end
                if (!seen) check("t5_valid_timeout", 64'(out_valid), 64'd1);
                for (int c = 0; c < 20; c++) begin
                    check("t5_hold_data", 64'(out_data), 64'(exp_q[0]));
                    check("t5_hold_rdy",  64'(in_ready), 64'd0);
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
            send(PE_LIST[0], 4'h0, 8'd1);
        join
        send_all(3, 0);
        wait_idle("t5");
        check("t5_spk", 64'(last_spk), 64'd1);
        check("t5_res", 64'(last_res), 64'd37);

        // T6: reset mid-timestep discards partial sums
        for (int i = 0; i < 5; i++) send(PE_LIST[i], 4'h0, 8'(i + 1));
        rst_n = 1'b0;
        m_acc = 0;
        m_mem = 0;
        ts_exp = 0;
        foreach (m_mask[i]) m_mask[i] = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_reset("t6_rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_all(7, -1);
        wait_idle("t6");
        check("t6_spk", 64'(last_spk), 64'd0);
        check("t6_res", 64'(last_res), 64'd55);

        check("err_total", 64'(err_seen), 64'(err_exp));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
